keypad_collector: RTL and testbench

Scans a 4x4 matrix keypad, debounces key presses and assembles typed digits into a 20-digit `senhaPac_t` packet with a one-cycle `digitos_valid` strobe. Sits directly upstream of the setup and password-check stages, which consume `digitos_value`/`digitos_valid`. Emits the control packets those stages decode: all-F for empty submit, all-B for exit, all-E for timeout.

---
 rtl/keypad_collector.sv | 217 +++++++++++++++++++++
 tb/tb_keypad_collector.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_collector.sv
// 4x4 keypad scanner/debouncer that assembles digits into a 20-nibble packet with submit/exit/timeout codes.
// Optional inactivity timeout (all-E packet) is built only when KEYPAD_TIMEOUT_EN is defined.
typedef logic [19:0][3:0] senhaPac_t;

module keypad_collector #(
  parameter int unsigned SCAN_CYCLES     = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned TIMEOUT_CYCLES  = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] col_matrix,
  output logic [3:0] lin_matrix,
  output senhaPac_t  digitos_value,
  output logic       digitos_valid,
  output logic       key_pressed
);

  if (SCAN_CYCLES < 1 || DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("keypad_collector: cycle parameters must be at least 1");
  end

  localparam int SCAN_W = $clog2(SCAN_CYCLES + 1);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam senhaPac_t PKT_EMPTY = {20{4'hF}};
  localparam senhaPac_t PKT_EXIT  = {20{4'hB}};

  typedef enum logic [2:0] {SCAN, DEB_PRESS, PRESSED, WAIT_REL, DEB_REL} state_t;

  state_t            state_q, state_d;
  logic [1:0]        ri_q, ri_d, ci_q, ci_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  senhaPac_t         buf_q, buf_d, pkt, val_q;
  logic [4:0]        cnt_q, cnt_d;
  logic              valid_q, valid_d, key_q, key_d;
  logic [3:0]        lin_q;
  logic [3:0]        code;
  logic              col_hi;

`ifdef KEYPAD_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;
`endif

  // Key code: 0-9 digits, A-D letters, E = '*', F = '#'.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'b00_00: key_code = 4'h1;
      4'b00_01: key_code = 4'h2;
      4'b00_10: key_code = 4'h3;
      4'b00_11: key_code = 4'hA;
      4'b01_00: key_code = 4'h4;
      4'b01_01: key_code = 4'h5;
      4'b01_10: key_code = 4'h6;
      4'b01_11: key_code = 4'hB;
      4'b10_00: key_code = 4'h7;
      4'b10_01: key_code = 4'h8;
      4'b10_10: key_code = 4'h9;
      4'b10_11: key_code = 4'hC;
      4'b11_00: key_code = 4'hE;
      4'b11_01: key_code = 4'h0;
      4'b11_10: key_code = 4'hF;
      default:  key_code = 4'hD;
    endcase
  endfunction

  function automatic logic [1:0] low_col(input logic [3:0] col);
    if (!col[0])      low_col = 2'd0;
    else if (!col[1]) low_col = 2'd1;
    else if (!col[2]) low_col = 2'd2;
    else              low_col = 2'd3;
  endfunction

  always_comb begin
    state_d    = state_q;
    ri_d       = ri_q;
    ci_d       = ci_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    col_hi     = col_matrix[ci_q];
    if (!enable) begin
      state_d    = SCAN;
      ri_d       = 2'd0;
      scan_cnt_d = '0;
      deb_cnt_d  = '0;
    end else begin
      case (state_q)
        SCAN: begin
          if (col_matrix != 4'hF) begin
            state_d    = DEB_PRESS;
            ci_d       = low_col(col_matrix);
            scan_cnt_d = '0;
            deb_cnt_d  = '0;
          end else if (scan_cnt_q >= SCAN_LAST) begin
            ri_d       = ri_q + 2'd1;
            scan_cnt_d = '0;
          end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
          end
        end
        DEB_PRESS: begin
          if (col_hi) begin
            state_d    = SCAN;
            scan_cnt_d = '0;
          end else if (deb_cnt_q >= DEB_LAST) begin
            state_d = PRESSED;
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end
        PRESSED: state_d = WAIT_REL;
        WAIT_REL: begin
          if (col_hi) begin
            state_d   = DEB_REL;
            deb_cnt_d = '0;
          end
        end
        DEB_REL: begin
          if (!col_hi) begin
            state_d = WAIT_REL;
          end else if (deb_cnt_q >= DEB_LAST) begin
            state_d    = SCAN;
            scan_cnt_d = '0;
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // Entry buffer, packet selection and (optionally) the inactivity timer.
  always_comb begin
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    key_d   = 1'b0;
    valid_d = 1'b0;
    pkt     = buf_q;
    code    = key_code(ri_q, ci_q);
    if (!enable) begin
      buf_d = PKT_EMPTY;
      cnt_d = 5'd0;
    end else if (state_q == PRESSED) begin
      key_d = 1'b1;
      if (code <= 4'h9) begin
        buf_d = {buf_q[18:0], code};
        if (cnt_q < 5'd20) cnt_d = cnt_q + 5'd1;
      end else if (code == 4'hF) begin
        valid_d = 1'b1;
        pkt     = (cnt_q == 5'd0) ? PKT_EMPTY : buf_q;
        buf_d   = PKT_EMPTY;
        cnt_d   = 5'd0;
      end else if (code == 4'hE) begin
        valid_d = 1'b1;
        pkt     = PKT_EXIT;
        buf_d   = PKT_EMPTY;
        cnt_d   = 5'd0;
      end
    end
`ifdef KEYPAD_TIMEOUT_EN
    else if (cnt_q != 5'd0 && tmr_q >= TMR_LAST) begin
      valid_d = 1'b1;
      pkt     = {20{4'hE}};
      buf_d   = PKT_EMPTY;
      cnt_d   = 5'd0;
    end
    if (!enable || key_d || valid_d || cnt_q == 5'd0) tmr_d = '0;
    else                                              tmr_d = tmr_q + 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SCAN;
      ri_q       <= 2'd0;
      ci_q       <= 2'd0;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      buf_q      <= PKT_EMPTY;
      cnt_q      <= 5'd0;
      valid_q    <= 1'b0;
      key_q      <= 1'b0;
      val_q      <= PKT_EMPTY;
      lin_q      <= 4'hF;
`ifdef KEYPAD_TIMEOUT_EN
      tmr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ri_q       <= ri_d;
      ci_q       <= ci_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      key_q      <= key_d;
      val_q      <= valid_d ? pkt : buf_d;
      lin_q      <= enable ? ~(4'b0001 << ri_d) : 4'hF;
`ifdef KEYPAD_TIMEOUT_EN
      tmr_q      <= tmr_d;
`endif
    end
  end

  assign lin_matrix    = lin_q;
  assign digitos_value = val_q;
  assign digitos_valid = valid_q;
  assign key_pressed   = key_q;

endmodule

// File: tb/tb_keypad_collector.sv
// Directed bench for keypad_collector with a behavioural 4x4 keypad (SCAN=4, DEBOUNCE=8, TIMEOUT=200).
module tb_keypad_collector;

  logic             clk = 1'b0;
  logic             rst, enable;
  logic [3:0]       col_matrix, lin_matrix;
  logic [19:0][3:0] digitos_value;
  logic             digitos_valid, key_pressed;

  logic             held = 1'b0, bounce = 1'b0;
  logic [1:0]       kr = 2'd0, kc = 2'd0;
  int               errors = 0, checks = 0;
  int               kp_cnt = 0, strb_cnt = 0, dbl = 0;
  logic             prev_v = 1'b0;
  logic [19:0][3:0] last_pkt;

  localparam logic [79:0] ALL_F = {20{4'hF}};
  localparam logic [79:0] ALL_B = {20{4'hB}};
  localparam logic [79:0] ALL_E = {20{4'hE}};

  keypad_collector #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8), .TIMEOUT_CYCLES(200)) dut (
    .clk(clk), .rst(rst), .enable(enable), .col_matrix(col_matrix), .lin_matrix(lin_matrix),
    .digitos_value(digitos_value), .digitos_valid(digitos_valid), .key_pressed(key_pressed)
  );

  always #5 clk = ~clk;

  // Pressed key shorts its column to the row only while that row is driven low.
  always_comb begin
    col_matrix = 4'hF;
    if ((held && !lin_matrix[kr]) || bounce) col_matrix[kc] = 1'b0;
  end

  always @(posedge clk) begin
    if (key_pressed) kp_cnt <= kp_cnt + 1;
    if (digitos_valid) begin
      strb_cnt <= strb_cnt + 1;
      last_pkt <= digitos_value;
      if (prev_v) dbl <= dbl + 1;
    end
    prev_v <= digitos_valid;
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns cycles from first low column to key_pressed, plus the T+1 and T+2 outputs.
  task automatic press(input logic [1:0] r, input logic [1:0] c, output int lat,
                       output logic v, output logic [79:0] val, output logic [79:0] post);
    int n;
    n = 0;
    while (lin_matrix[r] !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    chk("row_reached", {79'd0, lin_matrix[r]}, 80'd0);
    kr = r; kc = c; held = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (key_pressed !== 1'b1 && lat < 100);
    chk("key_seen", {79'd0, key_pressed}, 80'd1);
    v = digitos_valid; val = digitos_value;
    @(negedge clk);
    post = digitos_value;
    held = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  function automatic logic [3:0] digit_pos(input int d);
    int k;
    if (d == 0) return 4'b11_01;
    k = d - 1;
    digit_pos = {2'(k / 3), 2'(k % 3)};
  endfunction

  initial begin
    int lat, kp0, st0;
    logic v;
    logic [79:0] val, post, exp;
    logic [3:0] p;

    rst = 1'b1; enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_value", digitos_value, ALL_F);
    chk("rst_valid", {79'd0, digitos_valid}, 80'd0);
    chk("rst_key", {79'd0, key_pressed}, 80'd0);
    chk("rst_lin", {76'd0, lin_matrix}, 80'hF);
    rst = 1'b0;
    @(negedge clk);

    // 1,2,3,4 then '#'
    kp0 = kp_cnt; st0 = strb_cnt;
    press(2'd0, 2'd0, lat, v, val, post);
    chk("latency", 80'(lat), 80'd10);
    chk("buf_1", val, {{19{4'hF}}, 4'h1});
    press(2'd0, 2'd1, lat, v, val, post);
    press(2'd0, 2'd2, lat, v, val, post);
    press(2'd1, 2'd0, lat, v, val, post);
    chk("buf_1234", val, {{16{4'hF}}, 16'h1234});
    chk("digit_no_strobe", {79'd0, v}, 80'd0);
    press(2'd3, 2'd2, lat, v, val, post);
    chk("submit_valid", {79'd0, v}, 80'd1);
    chk("submit_pkt", val, {{16{4'hF}}, 16'h1234});
    chk("submit_cleared", post, ALL_F);
    chk("kp_count_5", 80'(kp_cnt - kp0), 80'd5);
    chk("strobes_1", 80'(strb_cnt - st0), 80'd1);

    // empty submit, exit after a digit, letter key
    press(2'd3, 2'd2, lat, v, val, post);
    chk("empty_submit_valid", {79'd0, v}, 80'd1);
    chk("empty_submit_pkt", val, ALL_F);
    press(2'd1, 2'd1, lat, v, val, post);
    chk("buf_5", val, {{19{4'hF}}, 4'h5});
    press(2'd3, 2'd0, lat, v, val, post);
    chk("exit_valid", {79'd0, v}, 80'd1);
    chk("exit_pkt", val, ALL_B);
    chk("exit_cleared", post, ALL_F);
    kp0 = kp_cnt; st0 = strb_cnt;
    press(2'd0, 2'd3, lat, v, val, post);
    chk("letter_no_strobe", {79'd0, v}, 80'd0);
    chk("letter_buf", val, ALL_F);
    chk("letter_kp", 80'(kp_cnt - kp0), 80'd1);

    // bounce shorter than the debounce window, then a long hold
    kp0 = kp_cnt; st0 = strb_cnt;
    kc = 2'd1;
    repeat (5) begin
      bounce = 1'b1; repeat (3) @(negedge clk);
      bounce = 1'b0; repeat (3) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    chk("bounce_no_key", 80'(kp_cnt - kp0), 80'd0);
    kr = 2'd3; kc = 2'd3; held = 1'b1;
    repeat (1000) @(negedge clk);
    held = 1'b0;
    repeat (30) @(negedge clk);
    chk("hold_one_key", 80'(kp_cnt - kp0), 80'd1);
    chk("hold_no_strobe", 80'(strb_cnt - st0), 80'd0);

    // 21 digits overflow the buffer
    for (int i = 0; i < 21; i++) begin
      p = digit_pos(i % 10);
      press(p[3:2], p[1:0], lat, v, val, post);
    end
    for (int k = 0; k < 20; k++) exp[k*4 +: 4] = 4'((20 - k) % 10);
    press(2'd3, 2'd2, lat, v, val, post);
    chk("overflow_valid", {79'd0, v}, 80'd1);
    chk("overflow_pkt", val, exp);

    // inactivity behaviour
    press(2'd2, 2'd0, lat, v, val, post);
    st0 = strb_cnt;
`ifdef KEYPAD_TIMEOUT_EN
    repeat (250) @(negedge clk);
    chk("timeout_one_strobe", 80'(strb_cnt - st0), 80'd1);
    chk("timeout_pkt", last_pkt, ALL_E);
    chk("timeout_cleared", digitos_value, ALL_F);
    st0 = strb_cnt;
    repeat (300) @(negedge clk);
    chk("idle_empty_no_strobe", 80'(strb_cnt - st0), 80'd0);
`else
    repeat (1000) @(negedge clk);
    chk("no_timeout_strobe", 80'(strb_cnt - st0), 80'd0);
    chk("buffer_persists", digitos_value, {{19{4'hF}}, 4'h7});
`endif

    // enable drop during press debounce
    kp0 = kp_cnt; st0 = strb_cnt;
    while (lin_matrix[2] !== 1'b0) @(negedge clk);
    kr = 2'd2; kc = 2'd2; held = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("dis_lin", {76'd0, lin_matrix}, 80'hF);
    chk("dis_buf", digitos_value, ALL_F);
    repeat (20) @(negedge clk);
    held = 1'b0;
    enable = 1'b1;
    repeat (40) @(negedge clk);
    chk("dis_no_key", 80'(kp_cnt - kp0), 80'd0);
    chk("dis_no_strobe", 80'(strb_cnt - st0), 80'd0);

    // reset during press debounce
    while (lin_matrix[2] !== 1'b0) @(negedge clk);
    held = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid_lin", {76'd0, lin_matrix}, 80'hF);
    held = 1'b0;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_mid_no_key", 80'(kp_cnt - kp0), 80'd0);
    chk("rst_mid_no_strobe", 80'(strb_cnt - st0), 80'd0);
    chk("no_back_to_back", 80'(dbl), 80'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
